reg_dest_scoreboard: RTL and testbench

- Parametrised successor to the CPU's write-destination register mux.
- Decodes the destination register from N selectable sources (rt, rd, $sp, $ra, immediate-derived) and registers it for the write-back stage.
- Tracks outstanding writes per architectural register in a scoreboard, so the control unit can stall on read-after-write hazards.
- Sits between the control unit/decode stage and the register file write port.

---
 rtl/reg_dest_scoreboard.sv | 118 +++++++++++
 tb/tb_reg_dest_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_dest_scoreboard.sv
// Destination-register decode for write-back, plus a per-register pending-write
// scoreboard used by the control unit to stall on read-after-write hazards.
module reg_dest_scoreboard #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned SP_REG   = 29,
  parameter int unsigned RA_REG   = 31,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SEL_W-1:0]    dst_sel,
  input  logic [REG_BITS-1:0] rt_field,
  input  logic [REG_BITS-1:0] rd_field,
  input  logic [IMM_W-1:0]    imm_field,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_reg,
  input  logic [REG_BITS-1:0] rs_q,
  input  logic [REG_BITS-1:0] rt_q,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic [REG_BITS-1:0] dst_out,
  output logic                dst_valid,
  output logic                sel_err,
  output logic                wb_err,
  output logic                any_pending
);

  localparam int unsigned NREGS   = 2 ** REG_BITS;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  logic [CNT_W-1:0]    cnt [NREGS];
  logic [REG_BITS-1:0] dec_idx;
  logic                dec_legal;
  logic                accept;
  logic                inc_en;
  logic                wb_hit;
  logic                wb_dec;
  logic [NREGS-1:0]    inc_vec;
  logic [NREGS-1:0]    dec_vec;

  // Upper immediate bits are deliberately discarded by the truncating decode.
  generate
    if (IMM_W > REG_BITS) begin : g_imm_hi
      logic imm_hi_unused;
      assign imm_hi_unused = ^imm_field[IMM_W-1:REG_BITS];
    end
  endgenerate

  // Destination decode
  always_comb begin
    dec_idx   = '0;
    dec_legal = 1'b1;
    case (dst_sel)
      SEL_W'(0): dec_idx = rt_field;
      SEL_W'(1): dec_idx = rd_field;
      SEL_W'(2): dec_idx = REG_BITS'(SP_REG);
      SEL_W'(3): dec_idx = REG_BITS'(RA_REG);
      SEL_W'(4): dec_idx = imm_field[REG_BITS-1:0];
      default:   dec_legal = 1'b0;
    endcase
  end

  // Back-pressure only when a real destination's counter is saturated
  assign issue_ready = !(dec_legal && (dec_idx != '0) && (cnt[dec_idx] == CNT_W'(CNT_MAX)));
  assign accept      = issue_valid && issue_ready;
  assign inc_en      = accept && dec_legal && (dec_idx != '0);
  assign wb_hit      = wb_valid && (wb_reg != '0);
  assign wb_dec      = wb_hit && (cnt[wb_reg] != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[dec_idx] = 1'b1;
    if (wb_dec) dec_vec[wb_reg]  = 1'b1;
  end

  // Pending counters; register 0 never gets an inc/dec bit so it stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec_vec[i] && !inc_vec[i])
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Registered write-back destination and error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_out   <= '0;
      dst_valid <= 1'b0;
      sel_err   <= 1'b0;
      wb_err    <= 1'b0;
    end else begin
      dst_valid <= accept && dec_legal;
      sel_err   <= accept && !dec_legal;
      wb_err    <= wb_hit && (cnt[wb_reg] == '0);
      if (accept && dec_legal) dst_out <= dec_idx;
    end
  end

  assign rs_busy = (cnt[rs_q] != '0);
  assign rt_busy = (cnt[rt_q] != '0);

  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < NREGS; i++) any_pending = any_pending | (cnt[i] != '0);
  end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench for reg_dest_scoreboard: decode, scoreboard counting,
// saturation, simultaneous issue/write-back, register 0 and reset behaviour.
module tb_reg_dest_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dst_sel;
  logic [4:0] rt_field, rd_field;
  logic [15:0] imm_field;
  logic       issue_valid, issue_ready;
  logic       wb_valid;
  logic [4:0] wb_reg, rs_q, rt_q;
  logic       rs_busy, rt_busy;
  logic [4:0] dst_out;
  logic       dst_valid, sel_err, wb_err, any_pending;

  int n_cmp = 0;
  int n_err = 0;

  reg_dest_scoreboard dut (
    .clk(clk), .reset(reset), .dst_sel(dst_sel), .rt_field(rt_field),
    .rd_field(rd_field), .imm_field(imm_field), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .rs_q(rs_q), .rt_q(rt_q), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .dst_out(dst_out), .dst_valid(dst_valid), .sel_err(sel_err),
    .wb_err(wb_err), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_one(input logic [4:0] r);
    issue_valid = 1'b0; wb_valid = 1'b1; wb_reg = r;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++; if (dst_out !== 5'd0 || dst_valid !== 1'b0 || sel_err !== 1'b0 || wb_err !== 1'b0) begin
      $display("FAIL reset_regs: got out=%0d v=%b se=%b we=%b want 0 0 0 0", dst_out, dst_valid, sel_err, wb_err); n_err++; end
    n_cmp++; if (issue_ready !== 1'b1 || any_pending !== 1'b0) begin
      $display("FAIL reset_ready: got rdy=%b pend=%b want 1 0", issue_ready, any_pending); n_err++; end
    reset = 1'b0;
    // Issue rd=8 then reset asynchronously before any write-back
    issue_valid = 1'b1; dst_sel = 3'd1; rd_field = 5'd8; rs_q = 5'd8;
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (dst_out !== 5'd8 || dst_valid !== 1'b1 || rs_busy !== 1'b1) begin
      $display("FAIL pre_reset_issue: got out=%0d v=%b busy=%b want 8 1 1", dst_out, dst_valid, rs_busy); n_err++; end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (dst_out !== 5'd0 || dst_valid !== 1'b0 || rs_busy !== 1'b0 || any_pending !== 1'b0 || issue_ready !== 1'b1) begin
      $display("FAIL async_reset: got out=%0d v=%b busy=%b pend=%b rdy=%b want 0 0 0 0 1",
               dst_out, dst_valid, rs_busy, any_pending, issue_ready); n_err++; end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_decode();
    logic [2:0] sels [5];
    logic [4:0] exp  [5];
    sels = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    exp  = '{5'd5, 5'd9, 5'd29, 5'd31, 5'd20};
    rt_field = 5'd5; rd_field = 5'd9; imm_field = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      issue_valid = 1'b1; dst_sel = sels[k];
      tick();
      n_cmp++; if (dst_out !== exp[k] || dst_valid !== 1'b1 || sel_err !== 1'b0) begin
        $display("FAIL decode_sel%0d: got out=%0d v=%b se=%b want %0d 1 0", sels[k], dst_out, dst_valid, sel_err, exp[k]); n_err++; end
    end
    dst_sel = 3'd6;
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (sel_err !== 1'b1 || dst_valid !== 1'b0 || dst_out !== 5'd20) begin
      $display("FAIL illegal_sel: got se=%b v=%b out=%0d want 1 0 20", sel_err, dst_valid, dst_out); n_err++; end
    tick();
    n_cmp++; if (sel_err !== 1'b0 || any_pending !== 1'b1) begin
      $display("FAIL sel_err_pulse: got se=%b pend=%b want 0 1", sel_err, any_pending); n_err++; end
    for (int k = 0; k < 5; k++) begin
      wb_one(exp[k]);
      n_cmp++; if (wb_err !== 1'b0) begin
        $display("FAIL drain_wb%0d: got we=%b want 0", exp[k], wb_err); n_err++; end
    end
    n_cmp++; if (any_pending !== 1'b0) begin
      $display("FAIL drain_pending: got %b want 0", any_pending); n_err++; end
  endtask

  task automatic test_saturation();
    dst_sel = 3'd3; rs_q = 5'd31;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (issue_ready !== 1'b1) begin
        $display("FAIL sat_ready%0d: got %b want 1", k, issue_ready); n_err++; end
      issue_valid = 1'b1;
      tick();
    end
    issue_valid = 1'b0;
    n_cmp++; if (rs_busy !== 1'b1 || issue_ready !== 1'b0) begin
      $display("FAIL sat_full: got busy=%b rdy=%b want 1 0", rs_busy, issue_ready); n_err++; end
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (dst_valid !== 1'b0) begin
      $display("FAIL sat_blocked: got v=%b want 0", dst_valid); n_err++; end
    // Saturated issue plus write-back: no accept, decrement applies
    issue_valid = 1'b1; wb_valid = 1'b1; wb_reg = 5'd31;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (issue_ready !== 1'b1 || dst_valid !== 1'b0 || wb_err !== 1'b0) begin
      $display("FAIL sat_wb: got rdy=%b v=%b we=%b want 1 0 0", issue_ready, dst_valid, wb_err); n_err++; end
    wb_one(5'd31);
    wb_one(5'd31);
    n_cmp++; if (rs_busy !== 1'b0 || any_pending !== 1'b0) begin
      $display("FAIL sat_drain: got busy=%b pend=%b want 0 0", rs_busy, any_pending); n_err++; end
  endtask

  task automatic test_simultaneous();
    dst_sel = 3'd0; rt_field = 5'd7; rt_q = 5'd7;
    issue_valid = 1'b1;
    tick();
    wb_valid = 1'b1; wb_reg = 5'd7;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (rt_busy !== 1'b1 || wb_err !== 1'b0 || dst_valid !== 1'b1) begin
      $display("FAIL simul_nonzero: got busy=%b we=%b v=%b want 1 0 1", rt_busy, wb_err, dst_valid); n_err++; end
    wb_one(5'd7);
    n_cmp++; if (rt_busy !== 1'b0 || wb_err !== 1'b0) begin
      $display("FAIL simul_drain: got busy=%b we=%b want 0 0", rt_busy, wb_err); n_err++; end
    issue_valid = 1'b1; wb_valid = 1'b1; wb_reg = 5'd7;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (rt_busy !== 1'b1 || wb_err !== 1'b1 || dst_valid !== 1'b1) begin
      $display("FAIL simul_zero: got busy=%b we=%b v=%b want 1 1 1", rt_busy, wb_err, dst_valid); n_err++; end
    tick();
    n_cmp++; if (wb_err !== 1'b0 || rt_busy !== 1'b1) begin
      $display("FAIL simul_zero_pulse: got we=%b busy=%b want 0 1", wb_err, rt_busy); n_err++; end
    wb_one(5'd7);
  endtask

  task automatic test_reg0();
    dst_sel = 3'd0; rt_field = 5'd0; rs_q = 5'd0;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (dst_valid !== 1'b1 || dst_out !== 5'd0 || any_pending !== 1'b0 || rs_busy !== 1'b0) begin
      $display("FAIL reg0_issue: got v=%b out=%0d pend=%b busy=%b want 1 0 0 0", dst_valid, dst_out, any_pending, rs_busy); n_err++; end
    wb_one(5'd0);
    n_cmp++; if (wb_err !== 1'b0) begin
      $display("FAIL reg0_wb: got we=%b want 0", wb_err); n_err++; end
  endtask

  task automatic test_spurious_wb();
    wb_one(5'd12);
    n_cmp++; if (wb_err !== 1'b1 || any_pending !== 1'b0) begin
      $display("FAIL spurious_wb: got we=%b pend=%b want 1 0", wb_err, any_pending); n_err++; end
    tick();
    n_cmp++; if (wb_err !== 1'b0) begin
      $display("FAIL spurious_pulse: got we=%b want 0", wb_err); n_err++; end
  endtask

  initial begin
    reset = 1'b1; dst_sel = '0; rt_field = '0; rd_field = '0; imm_field = '0;
    issue_valid = 1'b0; wb_valid = 1'b0; wb_reg = '0; rs_q = '0; rt_q = '0;
    test_reset();
    test_decode();
    test_saturation();
    test_simultaneous();
    test_reg0();
    test_spurious_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
